// File: rtl/split_stream_checker_if.sv
// Beat stream in, verdict stream out, for the split stream checker.
// The master side is the enumerator/collector pair; the slave side is the checker.
interface split_stream_checker_if #(
   parameter int NUM_VARS = 50,
   parameter int W        = 8,
   parameter int SUM_W    = W + $clog2(NUM_VARS) + 1
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic             in_last;
   logic [1:0]       mode;
   logic [SUM_W-1:0] bound;
   logic             x_valid;
   logic             x_ready;
   logic             x;
   logic             err;

   modport master (
      output in_valid, in_data, in_last, mode, bound, x_ready,
      input  in_ready, x_valid, x, err
   );

   modport slave (
      input  in_valid, in_data, in_last, mode, bound, x_ready,
      output in_ready, x_valid, x, err
   );
endinterface

// File: rtl/split_stream_checker.sv
// Accumulates one frame of variable beats and emits a single constraint verdict
// (always-true, sum bound, even parity or all-nonzero) plus a frame length error.
module split_stream_checker #(
   parameter int NUM_VARS = 50,
   parameter int W        = 8,
   parameter int SUM_W    = W + $clog2(NUM_VARS) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   split_stream_checker_if.slave bus
);
   localparam int               CNT_W   = $clog2(NUM_VARS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_VARS);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       rst_sync_q, rst_sync_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [SUM_W-1:0] bound_q, bound_d;
   logic [1:0]       mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             par_q, par_d;
   logic             allnz_q, allnz_d;
   logic             x_q, x_d;
   logic             err_q, err_d;

   logic             first_beat;
   logic             accept;
   logic             frame_end;
   logic [SUM_W-1:0] sum_upd;
   logic [SUM_W-1:0] bound_eff;
   logic [1:0]       mode_eff;
   logic [CNT_W-1:0] cnt_upd;
   logic             par_upd;
   logic             allnz_upd;
   logic             verdict;

   assign bus.in_ready = (state_q != ST_DONE);
   assign bus.x_valid  = (state_q == ST_DONE);
   assign bus.x        = x_q;
   assign bus.err      = err_q;

   // Reset asserts asynchronously but the core only leaves reset two clocks
   // after rst_n rises, so all flops release on the same edge.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};

   assign first_beat = (state_q == ST_IDLE);
   assign accept     = bus.in_valid && bus.in_ready;

   // Values as they will be after the current beat; the first beat of a frame
   // starts from a clean slate and supplies mode/bound.
   assign sum_upd   = (first_beat ? '0 : sum_q) + SUM_W'(bus.in_data);
   assign par_upd   = (first_beat ? 1'b0 : par_q) ^ (^bus.in_data);
   assign allnz_upd = (first_beat ? 1'b1 : allnz_q) & (bus.in_data != '0);
   assign cnt_upd   = (first_beat ? '0 : cnt_q) + CNT_W'(1);
   assign mode_eff  = first_beat ? bus.mode  : mode_q;
   assign bound_eff = first_beat ? bus.bound : bound_q;
   assign frame_end = bus.in_last || (cnt_upd == CNT_MAX);

   always_comb begin
      verdict = 1'b1;
      unique case (mode_eff)
         2'd0: verdict = 1'b1;
         2'd1: verdict = (sum_upd <= bound_eff);
         2'd2: verdict = ~par_upd;
         2'd3: verdict = allnz_upd;
         default: verdict = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      bound_d = bound_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      allnz_d = allnz_q;
      x_d     = x_q;
      err_d   = err_q;

      unique case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               sum_d   = sum_upd;
               par_d   = par_upd;
               allnz_d = allnz_upd;
               cnt_d   = cnt_upd;
               mode_d  = mode_eff;
               bound_d = bound_eff;
               if (frame_end) begin
                  state_d = ST_DONE;
                  x_d     = verdict;
                  err_d   = !(bus.in_last && (cnt_upd == CNT_MAX));
               end else begin
                  state_d = ST_ACCUM;
               end
            end
         end
         ST_DONE: begin
            if (bus.x_ready) begin
               state_d = ST_IDLE;
               sum_d   = '0;
               par_d   = 1'b0;
               allnz_d = 1'b0;
               cnt_d   = '0;
               x_d     = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!rst_sync_q[1]) begin
         state_d = ST_IDLE;
         sum_d   = '0;
         bound_d = '0;
         mode_d  = '0;
         cnt_d   = '0;
         par_d   = 1'b0;
         allnz_d = 1'b0;
         x_d     = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
         state_q    <= ST_IDLE;
         sum_q      <= '0;
         bound_q    <= '0;
         mode_q     <= '0;
         cnt_q      <= '0;
         par_q      <= 1'b0;
         allnz_q    <= 1'b0;
         x_q        <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rst_sync_q <= rst_sync_d;
         state_q    <= state_d;
         sum_q      <= sum_d;
         bound_q    <= bound_d;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         par_q      <= par_d;
         allnz_q    <= allnz_d;
         x_q        <= x_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_split_stream_checker.sv
// Bench for split_stream_checker: directed frame table, hand-written corner
// sequences, and random frames checked against a frame-level reference model.
module tb_split_stream_checker;
   localparam int NV    = 50;
   localparam int W     = 8;
   localparam int SUM_W = W + $clog2(NV) + 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   split_stream_checker_if #(.NUM_VARS(NV), .W(W), .SUM_W(SUM_W)) bus();

   split_stream_checker #(.NUM_VARS(NV), .W(W), .SUM_W(SUM_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int   tests = 0;
   int   fails = 0;
   logic xr_rand  = 1'b0;
   logic xr_force = 1'b0;
   logic xr_rnd   = 1'b0;
   logic mon_en   = 1'b0;
   assign bus.x_ready = xr_rand ? xr_rnd : xr_force;

   typedef struct {
      string            name;
      logic [1:0]       mode;
      logic [SUM_W-1:0] bound;
      int               len;
      logic [W-1:0]     fill;
      int               sp_idx;
      logic [W-1:0]     sp_val;
      bit               last;
      bit               exp_x;
      bit               exp_err;
   } vec_t;

   typedef struct {
      logic [W-1:0]     d;
      bit               l;
      logic [1:0]       m;
      logic [SUM_W-1:0] b;
   } beat_t;

   vec_t       tbl[10];
   beat_t      stim[$];
   logic [1:0] expq[$];
   logic [1:0] got[$];
   int         hold_bad = 0;
   logic       pend = 1'b0;
   logic       px, pe;

   // Verdict collector for the random phase, plus hold-stability watch.
   always @(negedge clk) begin
      if (xr_rand) xr_rnd = 1'($urandom_range(0, 1));
      if (mon_en) begin
         if (pend && !(bus.x_valid === 1'b1 && bus.x === px && bus.err === pe))
            hold_bad++;
         pend = 1'b0;
         if (bus.x_valid === 1'b1) begin
            if (xr_rnd) got.push_back({bus.x, bus.err});
            else begin
               pend = 1'b1;
               px   = bus.x;
               pe   = bus.err;
            end
         end
      end
   end

   function automatic vec_t mk(input string nm, input logic [1:0] m, input int b, input int len,
                               input logic [W-1:0] fill, input int sp_idx, input logic [W-1:0] sp_val,
                               input bit last, input bit ex, input bit ee);
      vec_t v;
      v.name = nm; v.mode = m; v.bound = SUM_W'(b); v.len = len; v.fill = fill;
      v.sp_idx = sp_idx; v.sp_val = sp_val; v.last = last; v.exp_x = ex; v.exp_err = ee;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d", nm, act, req);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat was accepted.
   task automatic send_beat(input logic [W-1:0] d, input bit l, input logic [1:0] m,
                            input logic [SUM_W-1:0] b, input bit gaps);
      int t;
      int g;
      if (gaps) begin
         g = $urandom_range(0, 3);
         for (int i = 0; i < g; i++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = W'($urandom);
            @(negedge clk);
         end
      end
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l; bus.mode = m; bus.bound = b;
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk("in_ready_timeout", 32'(t), 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = W'($urandom);
      bus.mode = 2'($urandom); bus.bound = SUM_W'($urandom);
   endtask

   task automatic send_frame(input int len, input logic [W-1:0] fill, input int sp_idx,
                             input logic [W-1:0] sp_val, input bit last, input logic [1:0] m,
                             input logic [SUM_W-1:0] b);
      logic [W-1:0] d;
      for (int i = 0; i < len; i++) begin
         d = (i == sp_idx) ? sp_val : fill;
         if (i == 0) send_beat(d, last && (i == len - 1), m, b, 1'b0);
         else        send_beat(d, last && (i == len - 1), 2'($urandom), SUM_W'($urandom), 1'b0);
      end
   endtask

   // Verdict must be up one cycle after the last beat, then consumed.
   task automatic check_done(input string nm, input bit ex, input bit ee);
      chk({nm, "_xvalid"},   32'(bus.x_valid), 32'd1);
      chk({nm, "_x"},        32'(bus.x), 32'(ex));
      chk({nm, "_err"},      32'(bus.err), 32'(ee));
      chk({nm, "_inrdy_lo"}, 32'(bus.in_ready), 32'd0);
      xr_force = 1'b1;
      @(negedge clk);
      xr_force = 1'b0;
      chk({nm, "_xvalid_lo"}, 32'(bus.x_valid), 32'd0);
      chk({nm, "_inrdy_hi"},  32'(bus.in_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_inrdy"},  32'(bus.in_ready), 32'd1);
      chk({nm, "_xvalid"}, 32'(bus.x_valid), 32'd0);
      chk({nm, "_x"},      32'(bus.x), 32'd0);
      chk({nm, "_err"},    32'(bus.err), 32'd0);
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Frame-level reference: splits the beat stream into frames by last/count.
   task automatic build_model();
      int   cnt = 0, sum = 0, ones = 0, fb = 0;
      bit   nz = 1'b1, vx, ve;
      logic [1:0] fm = 2'd0;
      expq.delete();
      foreach (stim[k]) begin
         if (cnt == 0) begin
            fm = stim[k].m; fb = int'(stim[k].b); sum = 0; ones = 0; nz = 1'b1;
         end
         sum  += int'(stim[k].d);
         ones += $countones(stim[k].d);
         nz    = nz && (stim[k].d != 0);
         cnt++;
         if (stim[k].l || cnt == NV) begin
            case (fm)
               2'd0: vx = 1'b1;
               2'd1: vx = (sum <= fb);
               2'd2: vx = (ones % 2 == 0);
               default: vx = nz;
            endcase
            ve = !(stim[k].l && cnt == NV);
            expq.push_back({vx, ve});
            cnt = 0;
         end
      end
   endtask

   initial begin
      int t;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.mode = '0; bus.bound = '0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      release_reset();
      check_reset_outputs("post_reset");

      tbl[0] = mk("m1_eq",    2'd1, 2500,  50, 8'h32, -1, 8'h00, 1'b1, 1'b1, 1'b0);
      tbl[1] = mk("m1_over",  2'd1, 2499,  50, 8'h32, -1, 8'h00, 1'b1, 1'b0, 1'b0);
      tbl[2] = mk("m2_odd",   2'd2, 0,     50, 8'h00,  0, 8'h01, 1'b1, 1'b0, 1'b0);
      tbl[3] = mk("m2_even",  2'd2, 0,     50, 8'h00,  0, 8'h03, 1'b1, 1'b1, 1'b0);
      tbl[4] = mk("m3_zero",  2'd3, 0,     50, 8'h05, 17, 8'h00, 1'b1, 1'b0, 1'b0);
      tbl[5] = mk("m0_true",  2'd0, 0,     50, 8'h05, 17, 8'h00, 1'b1, 1'b1, 1'b0);
      tbl[6] = mk("short",    2'd3, 0,     10, 8'h01, -1, 8'h00, 1'b1, 1'b1, 1'b1);
      tbl[7] = mk("long",     2'd1, 0,     50, 8'h01, -1, 8'h00, 1'b0, 1'b0, 1'b1);
      tbl[8] = mk("m1_max",   2'd1, 12750, 50, 8'hff, -1, 8'h00, 1'b1, 1'b1, 1'b0);
      tbl[9] = mk("m3_allnz", 2'd3, 0,     50, 8'hff, -1, 8'h00, 1'b1, 1'b1, 1'b0);

      for (int i = 0; i < 10; i++) begin
         send_frame(tbl[i].len, tbl[i].fill, tbl[i].sp_idx, tbl[i].sp_val, tbl[i].last,
                    tbl[i].mode, tbl[i].bound);
         check_done(tbl[i].name, tbl[i].exp_x, tbl[i].exp_err);
         $display("[TB] vector %s mode=%0d done", tbl[i].name, tbl[i].mode);
      end

      // Long frame is cut at NUM_VARS; the 51st beat opens a new one-beat frame.
      send_frame(50, 8'h02, -1, 8'h00, 1'b0, 2'd1, SUM_W'(100));
      check_done("long2", 1'b1, 1'b1);
      send_beat(8'h07, 1'b1, 2'd2, SUM_W'(0), 1'b0);
      check_done("beat51", 1'b0, 1'b1);
      $display("[TB] long frame plus beat 51 done");

      // Verdict backpressure: held stable with intake stalled.
      send_frame(50, 8'h01, -1, 8'h00, 1'b1, 2'd1, SUM_W'(49));
      for (int k = 0; k < 5; k++) begin
         chk("bp_xvalid", 32'(bus.x_valid), 32'd1);
         chk("bp_x",      32'(bus.x), 32'd0);
         chk("bp_err",    32'(bus.err), 32'd0);
         chk("bp_inrdy",  32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      check_done("bp", 1'b0, 1'b0);
      $display("[TB] backpressure sequence done");

      // Reset while a verdict is pending drops it at once.
      send_frame(10, 8'h01, -1, 8'h00, 1'b1, 2'd0, SUM_W'(0));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_done");
      @(negedge clk);
      release_reset();

      // Reset mid-frame at beat 25, then a clean frame with no residue.
      send_frame(24, 8'h00, -1, 8'h00, 1'b0, 2'd3, SUM_W'(0));
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      release_reset();
      send_frame(50, 8'h01, -1, 8'h00, 1'b1, 2'd1, SUM_W'(50));
      check_done("after_rst", 1'b1, 1'b0);
      $display("[TB] reset sequences done");

      // Random frames, checked once with dense input and once with gaps.
      for (int f = 0; f < 25; f++) begin
         int         len  = $urandom_range(1, 60);
         bit         lf   = (f == 24) ? 1'b1 : ($urandom_range(0, 3) != 0);
         bit         zp   = 1'($urandom_range(0, 1));
         logic [1:0] m    = 2'($urandom_range(0, 3));
         int         b    = $urandom_range(0, 13000);
         beat_t      bt;
         for (int i = 0; i < len; i++) begin
            bt.d = (zp && $urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom_range(1, 255));
            bt.l = lf && (i == len - 1);
            bt.m = (i == 0) ? m : 2'($urandom);
            bt.b = (i == 0) ? SUM_W'(b) : SUM_W'($urandom_range(0, 13000));
            stim.push_back(bt);
         end
      end
      build_model();

      for (int pass = 0; pass < 2; pass++) begin
         got.delete();
         xr_rand = 1'b1;
         mon_en  = 1'b1;
         foreach (stim[k]) send_beat(stim[k].d, stim[k].l, stim[k].m, stim[k].b, pass == 1);
         t = 0;
         while (got.size() < expq.size() && t < 3000) begin
            @(negedge clk);
            t++;
         end
         mon_en  = 1'b0;
         xr_rand = 1'b0;
         @(negedge clk);
         chk($sformatf("rand_p%0d_count", pass), 32'(got.size()), 32'(expq.size()));
         for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            chk($sformatf("rand_p%0d_frame%0d", pass, i), 32'(got[i]), 32'(expq[i]));
            $display("[TB] pass %0d frame %0d x/err=%0b expected %0b", pass, i, got[i], expq[i]);
         end
      end
      chk("hold_stable", 32'(hold_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/split_stream_checker.md
Name: split_stream_checker

Overview:
- Sequential, parametrised successor to the fixed-width split constraint blocks.
- Instead of 50 parallel ports tied to a constant-true result, it accepts NUM_VARS variable assignments one beat at a time over a valid/ready stream.
- It evaluates a runtime-selectable constraint and returns a single verdict bit over an output handshake.
- It sits between the assignment enumerator and the BDD result collector.

Parameters:
- NUM_VARS, 50, number of variable beats per assignment frame (>=2)
- W, 8, beat data width; narrower variables are zero-extended by the sender
- SUM_W, W+$clog2(NUM_VARS)+1, accumulator and bound width; must never overflow

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid&&in_ready
- in_data  input  W  variable value
- in_last  input  1  marks final beat of frame
- mode  input  2  constraint select, sampled on first beat of frame
- bound  input  SUM_W  sum limit, sampled on first beat of frame
- x_valid  output  1  verdict valid
- x_ready  input  1  verdict consumed when x_valid&&x_ready
- x  output  1  verdict, 1 = constraint satisfied
- err  output  1  frame length error, qualified by x_valid

Behaviour:
- Reset (async assert, sync deassert internally):
  - state=IDLE, in_ready=1, x_valid=0, x=0, err=0.
  - Accumulators and counter are cleared.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: first accepted beat latches mode/bound, sets sum=in_data, par=^in_data, allnz=(in_data!=0), cnt=1.
    - If in_last is set or NUM_VARS is reached on that beat, go to DONE. Otherwise go to ACCUM.
  - ACCUM: each accepted beat does sum+=in_data, par^=^in_data, allnz&=(in_data!=0), cnt+=1.
    - Go to DONE when in_last is accepted, or when cnt reaches NUM_VARS.
  - DONE: in_ready=0, x_valid=1, x/err held stable until x_ready.
    - On handshake, go to IDLE with in_ready=1 the next cycle.
    - A back-to-back frame therefore has a 1-cycle bubble.
- Verdict, registered on the transition into DONE:
  - mode 0: x=1 (constant-true, legacy split behaviour).
  - mode 1: x = (sum <= bound), unsigned.
  - mode 2: x = ~par (even total bit parity).
  - mode 3: x = allnz.
- Latency: x_valid rises the cycle after the last beat is accepted.
- err rules:
  - err=1 if in_last arrives with cnt != NUM_VARS (short frame).
  - err=1 if cnt reaches NUM_VARS without in_last (long frame).
  - In both cases x is still computed over the beats accepted.
  - Beats after a forced termination belong to the next frame.
- mode/bound changes mid-frame are ignored. in_data is ignored when in_valid=0.
- x_ready while x_valid=0 has no effect. x_valid must not drop without a handshake.
- Reset mid-frame: the partial frame is discarded and no verdict is issued.
- Arithmetic: the sum is unsigned and zero-extended to SUM_W. The default SUM_W guarantees no wrap.

Test Plan:
1. Mode 1, NUM_VARS=50, bound=2500, 50 beats of 0x32 (sum 2500), last on beat 50 -> x_valid 1 cycle later, x=1, err=0. Repeat with bound=2499 -> x=0.
2. Mode 2, beats 0x01 then 49×0x00, last correct -> x=0. Change beat 1 to 0x03 -> x=1.
3. Mode 3 with one zero beat at index 17 -> x=0. Mode 0 same data -> x=1, err=0.
4. Short frame: in_last on beat 10 -> x_valid, err=1. Long frame: 50 beats with no last -> DONE after beat 50, err=1, and beat 51 starts a new frame.
5. Backpressure: hold x_ready=0 for 5 cycles -> x_valid/x/err stable and in_ready=0. Then x_ready=1 -> next cycle in_ready=1. Random in_valid gaps give the same verdict as dense input.
6. Assert rst_n=0 at beat 25 of a frame -> outputs return to reset values immediately. A following full frame produces the correct verdict with no residue.
